serial_shift_rx: RTL and testbench

SERIAL_SHIFT_RX -- requirements
Module: serial_shift_rx

---
 rtl/serial_shift_rx.sv | 143 ++++++++++++++
 tb/tb_serial_shift_rx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_shift_rx.sv
// Serial shift receiver: samples an asynchronous SCLK/SDATA/SLATCH link,
// assembles MSB-first frames and presents the last good frame on DATA.
// Build option: define SERIAL_SHIFT_RX_PARITY_EN to append an even-parity
// bit to each frame (frame width N+1); undefined means plain N-bit frames.
module serial_shift_rx #(
    parameter int unsigned N           = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         SCLK,
    input  logic         SDATA,
    input  logic         SLATCH,
    output logic [N-1:0] DATA,
    output logic         VALID,
    output logic         ERR,
    output logic         BUSY
);

`ifdef SERIAL_SHIFT_RX_PARITY_EN
    localparam int unsigned FW = N + 1;
`else
    localparam int unsigned FW = N;
`endif
    localparam int unsigned      CNT_W    = $clog2(FW + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FW);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(FW + 1);

    // Frame phase is a pure function of the bit count.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OVER  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdata_sync;
    logic [SYNC_STAGES-1:0] slatch_sync;
    logic                   sclk_dly;
    logic                   slatch_dly;
    logic                   sclk_rise;
    logic                   slatch_rise;
    logic                   sdata_s;

    logic [FW-1:0]          sr;
    logic [FW-1:0]          sr_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [N-1:0]           data_nxt;
    logic                   valid_nxt;
    logic                   err_nxt;
    logic [N-1:0]           frame_data;
    logic                   frame_ok;
    state_t                 state;

    // Synchronizers plus one delay flop for edge detection; clock-like lines
    // reset high so a line held high through reset release shows no edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sclk_sync   <= '1;
            slatch_sync <= '1;
            sdata_sync  <= '0;
            sclk_dly    <= 1'b1;
            slatch_dly  <= 1'b1;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            slatch_sync <= {slatch_sync[SYNC_STAGES-2:0], SLATCH};
            sdata_sync  <= {sdata_sync[SYNC_STAGES-2:0], SDATA};
            sclk_dly    <= sclk_sync[SYNC_STAGES-1];
            slatch_dly  <= slatch_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_rise   = sclk_sync[SYNC_STAGES-1] & ~sclk_dly;
    assign slatch_rise = slatch_sync[SYNC_STAGES-1] & ~slatch_dly;
    assign sdata_s     = sdata_sync[SYNC_STAGES-1];

    // Decode frame phase from the bit counter.
    always_comb begin
        state = SHIFT;
        if (cnt == '0) begin
            state = IDLE;
        end else if (cnt == CNT_OVER) begin
            state = OVER;
        end
    end

    assign BUSY = (state != IDLE);

    // Next-state: shift first, then judge the latch on the updated frame.
    always_comb begin
        sr_nxt     = sr;
        cnt_nxt    = cnt;
        data_nxt   = DATA;
        valid_nxt  = 1'b0;
        err_nxt    = 1'b0;
        frame_data = '0;
        frame_ok   = 1'b0;

        if (sclk_rise) begin
            sr_nxt = {sr[FW-2:0], sdata_s};
            if (state != OVER) begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end

`ifdef SERIAL_SHIFT_RX_PARITY_EN
        frame_data = sr_nxt[FW-1:1];
        frame_ok   = ~(^sr_nxt);
`else
        frame_data = sr_nxt;
        frame_ok   = 1'b1;
`endif

        if (slatch_rise) begin
            if ((cnt_nxt == CNT_FULL) && frame_ok) begin
                data_nxt  = frame_data;
                valid_nxt = 1'b1;
            end else begin
                err_nxt = 1'b1;
            end
            cnt_nxt = '0;
        end
    end

    // Frame state and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sr    <= '0;
            cnt   <= '0;
            DATA  <= '0;
            VALID <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            sr    <= sr_nxt;
            cnt   <= cnt_nxt;
            DATA  <= data_nxt;
            VALID <= valid_nxt;
            ERR   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_serial_shift_rx.sv
// Bench for serial_shift_rx: frame-level model with fixed input-to-output
// latency, per-cycle output comparison, directed and random frames.
module tb_serial_shift_rx;

    localparam int unsigned N = 8;
    localparam int unsigned S = 2;
`ifdef SERIAL_SHIFT_RX_PARITY_EN
    localparam int unsigned FW = N + 1;
`else
    localparam int unsigned FW = N;
`endif
    localparam int DEPTH = 32768;

    logic         clk = 1'b0;
    logic         rst;
    logic         sclk;
    logic         sdata;
    logic         slatch;
    logic [N-1:0] data;
    logic         valid;
    logic         err;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_seen = 0;
    int err_seen = 0;

    // Expected outputs indexed by clock cycle.
    bit           exp_set   [DEPTH];
    bit           exp_valid [DEPTH];
    bit           exp_err   [DEPTH];
    bit           exp_busy  [DEPTH];
    logic [N-1:0] exp_data  [DEPTH];

    // Frame-level model state.
    bit           frame_q[$];
    logic [N-1:0] m_data = '0;
    bit           prev_sclk = 1'b0;
    bit           prev_slatch = 1'b0;

    serial_shift_rx #(.N(N), .SYNC_STAGES(S)) dut (
        .CLK   (clk),
        .RST   (rst),
        .SCLK  (sclk),
        .SDATA (sdata),
        .SLATCH(slatch),
        .DATA  (data),
        .VALID (valid),
        .ERR   (err),
        .BUSY  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Single compare process: DUT outputs against the model on every cycle.
    always @(posedge clk) begin
        #1;
        if (cyc < DEPTH && exp_set[cyc]) begin
            chk("valid", 32'(valid), 32'(exp_valid[cyc]));
            chk("err",   32'(err),   32'(exp_err[cyc]));
            chk("busy",  32'(busy),  32'(exp_busy[cyc]));
            chk("data",  32'(data),  32'(exp_data[cyc]));
        end
        if (valid === 1'b1) valid_seen++;
        if (err === 1'b1) err_seen++;
    end

    function automatic void put(input int idx, input bit v, input bit e);
        if (idx < DEPTH) begin
            exp_set[idx]   = 1'b1;
            exp_valid[idx] = v;
            exp_err[idx]   = e;
            exp_data[idx]  = m_data;
            exp_busy[idx]  = (frame_q.size() > 0);
        end
    endfunction

    // Frame accepted only with exactly FW bits (and even parity when enabled).
    function automatic bit judge(output logic [N-1:0] d);
        logic [63:0] w;
        bit ok;
        w  = '0;
        ok = (frame_q.size() == FW);
        foreach (frame_q[i]) w = (w << 1) | 64'(frame_q[i]);
        d = N'(w >> (FW - N));
`ifdef SERIAL_SHIFT_RX_PARITY_EN
        ok = ok && ((^w) == 1'b0);
`endif
        return ok;
    endfunction

    // Drive one cycle of line values; effect appears S+1 edges later.
    task automatic step(input bit sc, input bit sd, input bit sl);
        bit v;
        bit e;
        logic [N-1:0] nd;
        @(posedge clk);
        #2;
        sclk   = sc;
        sdata  = sd;
        slatch = sl;
        v = 1'b0;
        e = 1'b0;
        if (sc && !prev_sclk) frame_q.push_back(sd);
        if (sl && !prev_slatch) begin
            if (judge(nd)) begin
                m_data = nd;
                v = 1'b1;
            end else begin
                e = 1'b1;
            end
            frame_q.delete();
        end
        prev_sclk   = sc;
        prev_slatch = sl;
        put(cyc + 1 + S, v, e);
    endtask

    task automatic do_reset();
        repeat (S + 1) step(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        frame_q.delete();
        m_data = '0;
        for (int i = 1; i <= int'(S) + 1; i++) put(cyc + i, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        put(cyc + 1 + S, 1'b0, 1'b0);
        repeat (S + 2) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bit(input bit b, input bit lat);
        int lo;
        int hi;
        lo = int'($urandom_range(S + 3, S + 1));
        hi = int'($urandom_range(S + 3, S + 1));
        repeat (lo) step(1'b0, b, 1'b0);
        repeat (hi) step(1'b1, b, lat);
    endtask

    task automatic latch_pulse();
        int lo;
        int hi;
        lo = int'($urandom_range(S + 3, S + 1));
        hi = int'($urandom_range(S + 3, S + 1));
        repeat (lo) step(1'b0, 1'b0, 1'b0);
        repeat (hi) step(1'b0, 1'b0, 1'b1);
        repeat (S + 1) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bits(input logic [63:0] bits, input int nb, input bit coinc);
        for (int i = nb - 1; i >= 0; i--) send_bit(bits[i], coinc && (i == 0));
    endtask

    task automatic send_frame(input logic [63:0] bits, input int nb, input bit coinc);
        send_bits(bits, nb, coinc && (nb > 0));
        if (coinc && nb > 0) repeat (S + 1) step(1'b0, 1'b0, 1'b0);
        else latch_pulse();
    endtask

    // Directed frame with hand-computed outcome; also pins the model.
    task automatic frame_check(input string name, input logic [63:0] bits, input int nb,
                               input bit coinc, input int ev, input int ee,
                               input logic [N-1:0] ed);
        int v0;
        int e0;
        v0 = valid_seen;
        e0 = err_seen;
        send_frame(bits, nb, coinc);
        repeat (S + 2) step(1'b0, 1'b0, 1'b0);
        chk({name, "_valid_cnt"}, 32'(valid_seen - v0), 32'(ev));
        chk({name, "_err_cnt"},   32'(err_seen - e0),   32'(ee));
        chk({name, "_data"},      32'(data),            32'(ed));
        chk({name, "_model"},     32'(m_data),          32'(ed));
        chk({name, "_busy"},      32'(busy),            32'd0);
    endtask

    initial begin
        logic [63:0] bits;
        logic [N-1:0] d;
        int nb;
        int r;
        bit coinc;
        rst    = 1'b0;
        sclk   = 1'b0;
        sdata  = 1'b0;
        slatch = 1'b0;
        #1;
        rst = 1'b1;
        for (int i = 1; i <= int'(S) + 1; i++) put(i, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        put(cyc + 1 + S, 1'b0, 1'b0);
        repeat (S + 2) step(1'b0, 1'b0, 1'b0);

        chk("rst_data",  32'(data),  32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_err",   32'(err),   32'd0);

`ifdef SERIAL_SHIFT_RX_PARITY_EN
        frame_check("par_ok",  64'h00F, 9, 1'b0, 1, 0, 8'h07);
        frame_check("par_bad", 64'h00E, 9, 1'b0, 0, 1, 8'h07);
`else
        frame_check("a5",       64'hA5,  8, 1'b0, 1, 0, 8'hA5);
        frame_check("short7",   64'h7F,  7, 1'b0, 0, 1, 8'hA5);
        frame_check("long9",    64'h13C, 9, 1'b0, 0, 1, 8'hA5);
        send_bits(64'hB, 4, 1'b0);
        repeat (S + 2) step(1'b1, 1'b0, 1'b0);
        chk("mid_busy", 32'(busy), 32'd1);
        do_reset();
        chk("rst2_data", 32'(data), 32'd0);
        chk("rst2_busy", 32'(busy), 32'd0);
        frame_check("after_rst", 64'h01, 8, 1'b0, 1, 0, 8'h01);
        frame_check("coinc_c3",  64'hC3, 8, 1'b1, 1, 0, 8'hC3);
        frame_check("idle_latch", 64'h0, 0, 1'b0, 0, 1, 8'hC3);
`endif

        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(99, 0));
            bits = {$urandom, $urandom};
            if (r < 65) begin
                nb = int'(FW);
            end else begin
                case ($urandom_range(4, 0))
                    0: nb = 0;
                    1: nb = 1;
                    2: nb = int'(FW) - 1;
                    3: nb = int'(FW) + 1;
                    default: nb = int'(FW) + 2;
                endcase
            end
`ifdef SERIAL_SHIFT_RX_PARITY_EN
            if (nb == int'(FW)) begin
                d = N'($urandom);
                bits = 64'({d, (^d) ^ ($urandom_range(9, 0) < 3)});
            end
`endif
            coinc = ($urandom_range(3, 0) == 0);
            if (r >= 94) begin
                send_bits(bits, int'($urandom_range(FW - 1, 1)), 1'b0);
                do_reset();
            end else begin
                send_frame(bits, nb, coinc);
            end
        end
        repeat (S + 4) step(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
